// File: rtl/fadd_issue_buffer.sv
// Valid/ready issue wrapper around a fixed-latency, non-stalling FP32 adder with a credit-guarded
// result FIFO. Define FADD_ISSUE_STATS_EN to add the issued/retired/NaN statistics counters.
module fadd_issue_buffer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LATENCY = 3,
   parameter int unsigned TAG_W   = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_a,
   input  logic [31:0]            in_b,
   input  logic [TAG_W-1:0]       in_tag,
   output logic [31:0]            add_a,
   output logic [31:0]            add_b,
   input  logic [31:0]            add_c,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_c,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_nan,
   output logic                   out_inf,
`ifdef FADD_ISSUE_STATS_EN
   output logic [31:0]            stat_issued,
   output logic [31:0]            stat_retired,
   output logic [31:0]            stat_nan,
`endif
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic                fire, push, pop;
   logic [LATENCY:1]    v_q;
   logic [TAG_W-1:0]    tag_q [1:LATENCY];
   logic [31:0]         mem_c [DEPTH];
   logic [TAG_W-1:0]    mem_tag [DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [CW-1:0]       count_q, count_d, inflight, occ;

   always_comb begin
      inflight = '0;
      for (int k = 1; k <= LATENCY; k++) inflight = inflight + CW'(v_q[k]);
   end

   // Credit counts both buffered results and every operation still inside the adder, so a
   // launched operation always has a FIFO slot waiting when it emerges.
   assign occ       = count_q + inflight;
   assign occupancy = rstn ? occ : '0;
   assign in_ready  = rstn & (occ < CW'(DEPTH));
   assign fire      = in_valid & in_ready;
   assign add_a     = in_a;
   assign add_b     = in_b;
   assign push      = v_q[LATENCY];
   assign out_valid = rstn & (count_q != '0);
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v_q     <= '0;
         for (int k = 1; k <= LATENCY; k++) tag_q[k] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         v_q[1]   <= fire;
         tag_q[1] <= in_tag;
         for (int k = 2; k <= LATENCY; k++) begin
            v_q[k]   <= v_q[k-1];
            tag_q[k] <= tag_q[k-1];
         end
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && push) begin
         mem_c[wr_q]   <= add_c;
         mem_tag[wr_q] <= tag_q[LATENCY];
      end
   end

   assign out_c   = mem_c[rd_q];
   assign out_tag = mem_tag[rd_q];
   assign out_nan = (out_c[30:23] == 8'hFF) && (out_c[22:0] != '0);
   assign out_inf = (out_c[30:23] == 8'hFF) && (out_c[22:0] == '0);

`ifdef FADD_ISSUE_STATS_EN
   logic [31:0] issued_q, retired_q, nan_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         issued_q  <= '0;
         retired_q <= '0;
         nan_q     <= '0;
      end else begin
         if (fire && issued_q != '1)            issued_q  <= issued_q + 32'd1;
         if (pop && retired_q != '1)            retired_q <= retired_q + 32'd1;
         if (pop && out_nan && nan_q != '1)     nan_q     <= nan_q + 32'd1;
      end
   end

   assign stat_issued  = issued_q;
   assign stat_retired = retired_q;
   assign stat_nan     = nan_q;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rstn) begin
         assert (!(push && count_q == CW'(DEPTH)))
            else $error("fadd_issue_buffer: capture into full result FIFO");
         assert (!(pop && count_q == '0))
            else $error("fadd_issue_buffer: pop from empty result FIFO");
      end
   end
`endif

endmodule

// File: tb/tb_fadd_issue_buffer.sv
// Directed bench for fadd_issue_buffer: a DEPTH=4 instance for the main checks and a DEPTH=8
// instance for streaming, each driving a behavioural 3-stage adder stand-in.
module tb_fadd_issue_buffer;

   localparam int unsigned TAG_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;

   logic             in_valid, in_ready, out_valid, out_ready, out_nan, out_inf;
   logic [31:0]      in_a, in_b, add_a, add_b, add_c, out_c;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [2:0]       occupancy;

   logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_nan, s_out_inf;
   logic [31:0]      s_in_a, s_in_b, s_add_a, s_add_b, s_add_c, s_out_c;
   logic [TAG_W-1:0] s_in_tag, s_out_tag;
   logic [3:0]       s_occupancy;

`ifdef FADD_ISSUE_STATS_EN
   logic [31:0] st_iss, st_ret, st_nan, s_st_iss, s_st_ret, s_st_nan;
`endif

   fadd_issue_buffer #(.DEPTH(4), .LATENCY(3), .TAG_W(TAG_W)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_c     (add_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_tag   (out_tag),
      .out_nan   (out_nan),
      .out_inf   (out_inf),
`ifdef FADD_ISSUE_STATS_EN
      .stat_issued  (st_iss),
      .stat_retired (st_ret),
      .stat_nan     (st_nan),
`endif
      .occupancy (occupancy)
   );

   // With DEPTH=LATENCY+1 the one-cycle delay on pop credit costs a bubble, so streaming at
   // one op per cycle is exercised on a deeper instance.
   fadd_issue_buffer #(.DEPTH(8), .LATENCY(3), .TAG_W(TAG_W)) u_dut8 (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_a      (s_in_a),
      .in_b      (s_in_b),
      .in_tag    (s_in_tag),
      .add_a     (s_add_a),
      .add_b     (s_add_b),
      .add_c     (s_add_c),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_c     (s_out_c),
      .out_tag   (s_out_tag),
      .out_nan   (s_out_nan),
      .out_inf   (s_out_inf),
`ifdef FADD_ISSUE_STATS_EN
      .stat_issued  (s_st_iss),
      .stat_retired (s_st_ret),
      .stat_nan     (s_st_nan),
`endif
      .occupancy (s_occupancy)
   );

   // Adder stand-in: exact IEEE results for the directed vectors, integer sum otherwise.
   function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000;
         {32'h7F800000, 32'hFF800000}: return 32'h7FC00000;
         {32'h7F800000, 32'h3F800000}: return 32'h7F800000;
         {32'h3F800000, 32'hBF800000}: return 32'h00000000;
         {32'h40400000, 32'h40A00000}: return 32'h41000000;
         {32'hFF800000, 32'hC0000000}: return 32'hFF800000;
         {32'h7FC00000, 32'h3F800000}: return 32'h7FC00000;
         default:                      return a + b;
      endcase
   endfunction

   logic [31:0] p1, p2, p3, q1, q2, q3;
   always @(posedge clk) begin
      p1 <= fadd_model(add_a, add_b);
      p2 <= p1;
      p3 <= p2;
      q1 <= fadd_model(s_add_a, s_add_b);
      q2 <= q1;
      q3 <= q2;
   end
   assign add_c   = p3;
   assign s_add_c = q3;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] c;
      logic        nan;
      logic        inf;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   int n_vec, n_bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int          lat, nf, rcv, first, last, drop, stale;
   logic        f;
   logic [3:0]  pat;
   logic [31:0] exp_c [16];
   logic [3:0]  exp_t [16];

   initial begin
      vecs[0] = '{a: 32'h3F800000, b: 32'h40000000, tag: 4'd5,  c: 32'h40400000, nan: 0, inf: 0};
      vecs[1] = '{a: 32'h7F800000, b: 32'hFF800000, tag: 4'd6,  c: 32'h7FC00000, nan: 1, inf: 0};
      vecs[2] = '{a: 32'h7F800000, b: 32'h3F800000, tag: 4'd7,  c: 32'h7F800000, nan: 0, inf: 1};
      vecs[3] = '{a: 32'h3F800000, b: 32'hBF800000, tag: 4'd8,  c: 32'h00000000, nan: 0, inf: 0};
      vecs[4] = '{a: 32'h40400000, b: 32'h40A00000, tag: 4'd9,  c: 32'h41000000, nan: 0, inf: 0};
      vecs[5] = '{a: 32'hFF800000, b: 32'hC0000000, tag: 4'd10, c: 32'hFF800000, nan: 0, inf: 1};
      vecs[6] = '{a: 32'h7FC00000, b: 32'h3F800000, tag: 4'd11, c: 32'h7FC00000, nan: 1, inf: 0};

      n_vec = 0;
      n_bad = 0;
      rstn = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_tag = '0; s_out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_occupancy", occupancy, 0);
      cyc();
      rstn = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);

      // Single operations from the table
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) begin
         in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_tag = vecs[i].tag;
         #1;
         chk("vec_in_ready", in_ready, 1);
         cyc();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 12) begin
            cyc();
            lat++;
         end
         chk("vec_latency", lat, 4);
         chk("vec_out_c", out_c, vecs[i].c);
         chk("vec_out_tag", out_tag, vecs[i].tag);
         chk("vec_out_nan", out_nan, vecs[i].nan);
         chk("vec_out_inf", out_inf, vecs[i].inf);
         cyc();
         chk("vec_drained", out_valid, 0);
      end

      // Back-pressure: in_valid held, consumer stalled
      out_ready = 1'b0;
      in_valid = 1'b1;
      nf = 0;
      for (int i = 0; i < 8; i++) begin
         in_tag = nf[3:0]; in_a = 32'h1000 + nf; in_b = 32'h20;
         #1;
         f = in_ready;
         cyc();
         if (f) nf++;
      end
      in_valid = 1'b0;
      #1;
      chk("bp_fires", nf, 4);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_occupancy", occupancy, 4);
      chk("bp_head_tag", out_tag, 0);
      cyc();
      chk("bp_stable_tag", out_tag, 0);
      chk("bp_stable_c", out_c, 32'h1020);
      out_ready = 1'b1;
      #1;
      chk("bp_no_early_credit", in_ready, 0);
      for (int j = 0; j < 4; j++) begin
         chk("bp_drain_valid", out_valid, 1);
         chk("bp_drain_tag", out_tag, j);
         chk("bp_drain_c", out_c, 32'h1020 + j);
         cyc();
         if (j == 0) chk("bp_credit_back", in_ready, 1);
      end
      chk("bp_empty", out_valid, 0);

      // Simultaneous capture and pop at full: 3 buffered plus 1 in flight
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_tag = 4'(i); in_a = 32'h2000 + i; in_b = '0;
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      cyc();
      chk("full_occupancy", occupancy, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_head_tag", out_tag, 0);
      out_ready = 1'b1;
      cyc();
      chk("full_occ_after_pp", occupancy, 3);
      for (int j = 1; j < 4; j++) begin
         chk("full_drain_tag", out_tag, j);
         chk("full_drain_c", out_c, 32'h2000 + j);
         cyc();
      end
      chk("full_empty", out_valid, 0);

      // Streaming on the deep instance
      s_out_ready = 1'b1;
      rcv = 0; first = -1; last = -1; drop = 0;
      for (int c = 0; c < 40; c++) begin
         if (s_out_valid) begin
            if (rcv < 16) begin
               chk("stream_c", s_out_c, exp_c[rcv]);
               chk("stream_tag", s_out_tag, exp_t[rcv]);
            end
            if (first < 0) first = c;
            last = c;
            rcv++;
         end
         if (c < 16) begin
            s_in_valid = 1'b1;
            s_in_a = 32'h5000 + c;
            s_in_b = 32'h100 * c;
            s_in_tag = 4'(c);
            exp_c[c] = (32'h5000 + c) + (32'h100 * c);
            exp_t[c] = 4'(c);
            #1;
            if (!s_in_ready) drop++;
         end else begin
            s_in_valid = 1'b0;
         end
         cyc();
      end
      chk("stream_count", rcv, 16);
      chk("stream_back_to_back", last - first, 15);
      chk("stream_ready_drops", drop, 0);

      // Reset while 2 ops are in flight and 1 is buffered
      out_ready = 1'b0;
      pat = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         in_valid = pat[i]; in_tag = 4'(8 + i); in_a = 32'h3000 + i; in_b = '0;
         cyc();
      end
      in_valid = 1'b0;
      chk("mid_pre_occupancy", occupancy, 3);
      chk("mid_pre_valid", out_valid, 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_occupancy", occupancy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      cyc();
      rstn = 1'b1;
      #1;
      chk("mid_post_occupancy", occupancy, 0);
      chk("mid_post_in_ready", in_ready, 1);
      out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) stale++;
         cyc();
      end
      chk("mid_no_stale", stale, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
